// File: rtl/mult32_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: FSM encoding,
// iteration constants and the operand magnitude helper.
package mult32_pkg;

    localparam int MULT_WIDTH   = 32;
    localparam int MULT_ITER    = 32;
    localparam int MULT_LATENCY = 35;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        NEG_LO = 3'd2,
        NEG_HI = 3'd3,
        DONE   = 3'd4
    } state_t;

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult32_seq_adder32.sv
// 32-bit ripple-carry adder shared with the ALU; reused here for both the
// partial-product accumulation and the final two's-complement negation.
module adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Result,
    output logic        Cout,
    output logic        Over
);

    logic carry;
    logic carry_into_msb;

    always_comb begin
        carry          = Cin;
        carry_into_msb = 1'b0;
        Result         = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                carry_into_msb = carry;
            end
            Result[i] = A[i] ^ B[i] ^ carry;
            carry     = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
        Over = carry ^ carry_into_msb;
    end

endmodule

// File: rtl/mult32_seq.sv
// Iterative radix-2 shift-add multiplier with fixed 35-cycle latency;
// signed operands are multiplied as magnitudes and the product negated at the end.
module mult32_seq
    import mult32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    generate
        if (WIDTH != MULT_WIDTH) begin : g_width_check
            $error("mult32_seq: WIDTH must be 32");
        end
    endgenerate

    localparam logic [4:0] LAST_ITER = 5'(MULT_ITER - 1);

    state_t      state_q, state_d;
    logic [31:0] mcand_q, hi_q, lo_q;
    logic [31:0] res_hi_q, res_lo_q;
    logic [4:0]  cnt_q;
    logic        neg_q, negc_q;

    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout, add_over_unused;

    adder32 u_adder (
        .A      (add_a),
        .B      (add_b),
        .Cin    (add_cin),
        .Result (add_sum),
        .Cout   (add_cout),
        .Over   (add_over_unused)
    );

    // Adder operands per state; in the NEG states the result is only used when neg_q is set.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            RUN: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : '0;
            end
            NEG_LO: begin
                add_a   = ~lo_q;
                add_cin = 1'b1;
            end
            NEG_HI: begin
                add_a   = ~hi_q;
                add_cin = negc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST_ITER) state_d = NEG_LO;
            NEG_LO:  state_d = NEG_HI;
            NEG_HI:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        result_hi = res_hi_q;
        result_lo = res_lo_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            negc_q   <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= signed_op ? abs32(a) : a;
                        lo_q    <= signed_op ? abs32(b) : b;
                        hi_q    <= '0;
                        cnt_q   <= '0;
                        neg_q   <= signed_op & (a[31] ^ b[31]);
                        negc_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // 65-bit {Cout, Result, lo} shifted right by one
                    hi_q  <= {add_cout, add_sum[31:1]};
                    lo_q  <= {add_sum[0], lo_q[31:1]};
                    cnt_q <= cnt_q + 5'd1;
                end
                NEG_LO: begin
                    if (neg_q) begin
                        lo_q   <= add_sum;
                        negc_q <= add_cout;
                    end else begin
                        negc_q <= 1'b0;
                    end
                end
                NEG_HI: begin
                    if (neg_q) begin
                        hi_q <= add_sum;
                    end
                    res_hi_q <= neg_q ? add_sum : hi_q;
                    res_lo_q <= lo_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: vector table plus handshake/reset
// sequences, with a done-cycle scoreboard.
module tb_mult32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result_hi, result_lo;

    mult32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [63:0] prod;
    } exp_t;

    vec_t vecs[14];
    exp_t sb_q[$];
    int   op_num = 0;
    int   k;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe, ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                err_cnt++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                op_num++;
                $display("op %0d: cycle %0d product 0x%08h_%08h", op_num, cyc, result_hi, result_lo);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("product", {result_hi, result_lo}, e.prod);
            end
        end
    end

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL timeout: got %0d pending results expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clk);
        start     = 1'b1;
        signed_op = v.s;
        a         = v.a;
        b         = v.b;
        sb_q.push_back('{cyc + 35, {v.hi, v.lo}});
        @(negedge clk);
        start     = 1'b0;
        signed_op = 1'($urandom_range(0, 1));
        a         = $urandom;
        b         = $urandom;
        wait_drain(60);
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("result_hold", {result_hi, result_lo}, {v.hi, v.lo});
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd3,          32'd5,          32'h00000000, 32'h0000000F};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{1'b1, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[3] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001};
        vecs[4] = '{1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
        vecs[5] = '{1'b1, 32'h80000000,   32'd1,          32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{1'b0, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
        vecs[7] = '{1'b1, 32'h7FFFFFFF,   32'h80000000,   32'hC0000000, 32'h80000000};
        vecs[8] = '{1'b1, 32'h00000000,   32'hFFFFFFFF,   32'h00000000, 32'h00000000};
        vecs[9] = '{1'b0, 32'h00010000,   32'h00010000,   32'h00000001, 32'h00000000};
        for (int i = 10; i < 14; i++) begin
            logic [63:0] p;
            vecs[i].s  = 1'($urandom_range(0, 1));
            vecs[i].a  = $urandom;
            vecs[i].b  = $urandom;
            p          = model(vecs[i].s, vecs[i].a, vecs[i].b);
            vecs[i].hi = p[63:32];
            vecs[i].lo = p[31:0];
        end

        // Reset state
        #3;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // First operation with cycle-exact busy profile
        @(negedge clk);
        check("busy_cycle0", 64'(busy), 64'd0);
        k = cyc;
        start = 1'b1; signed_op = vecs[0].s; a = vecs[0].a; b = vecs[0].b;
        sb_q.push_back('{k + 35, {vecs[0].hi, vecs[0].lo}});
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("busy_cycle%0d", i), 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("busy_cycle36", 64'(busy), 64'd0);
        wait_drain(5);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i]);
        end

        // Start while busy is ignored
        @(negedge clk);
        k = cyc;
        start = 1'b1; signed_op = 1'b0; a = 32'd7; b = 32'd9;
        sb_q.push_back('{k + 35, 64'd63});
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 10) @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd100;
        @(negedge clk);
        start = 1'b0;
        wait_drain(60);
        repeat (40) @(negedge clk);
        check("ignored_busy", 64'(busy), 64'd0);

        // Start held high: second op accepted only from IDLE
        @(negedge clk);
        k = cyc;
        start = 1'b1; signed_op = 1'b1; a = 32'hFFFFFFFD; b = 32'd7;
        sb_q.push_back('{k + 35, model(1'b1, 32'hFFFFFFFD, 32'd7)});
        sb_q.push_back('{k + 71, model(1'b1, 32'd6, 32'hFFFFFFF9)});
        while (cyc < k + 20) @(negedge clk);
        a = 32'd6; b = 32'hFFFFFFF9;
        while (cyc < k + 40) @(negedge clk);
        start = 1'b0;
        wait_drain(80);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-operation
        @(negedge clk);
        k = cyc;
        start = 1'b1; signed_op = 1'b0; a = 32'd11; b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(vecs[1]);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
Iterative radix-2 shift-add multiplier for the processor's execute stage. It computes a 64-bit product of two 32-bit operands, signed or unsigned. Each cycle's partial-product addition goes through the existing adder32 ripple-carry adder, and its Result/Cout are consumed directly. The block sits beside the ALU; the EX/hazard logic drives it with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width. Only 32 is legal; any other value must cause an elaboration error (`$error` in a generate check).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  input  32  multiplicand; sampled with start
b  input  32  multiplier; sampled with start
busy  output  1  high from the cycle after start acceptance through the DONE cycle
done  output  1  one-cycle pulse; result valid
result_hi  output  32  product bits [63:32]
result_lo  output  32  product bits [31:0]

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - busy = 0, done = 0, result_hi = 0, result_lo = 0.
  - Internal counters and accumulators cleared.
- States: IDLE, RUN, NEG_LO, NEG_HI, DONE. Encoding comes from the package.
- IDLE:
  - start=1 takes the edge IDLE->RUN.
  - At that edge, latch mcand = |a| and mplr = |b| when signed_op=1, else the raw values.
  - Set neg = signed_op & (a[31] ^ b[31]).
  - Clear hi = 0, lo = mplr, cnt = 0.
  - 0x80000000 magnitude is 0x80000000 (fits as unsigned); no special case.
- RUN, one iteration per cycle:
  - adder32 gets A = hi, B = lo[0] ? mcand : 0, Cin = 0.
  - {hi,lo} <= {Cout, Result, lo} >> 1, i.e. a 65-bit shift right by 1.
  - cnt increments; after the cnt=31 iteration, go to NEG_LO.
- NEG_LO:
  - If neg: adder32 gets A = ~lo, B = 0, Cin = 1; lo <= Result; negc <= Cout.
  - Else lo unchanged and negc = 0.
- NEG_HI:
  - If neg: adder32 gets A = ~hi, B = 0, Cin = negc; hi <= Result.
  - Else unchanged.
  - Adder Cout/Over are ignored here.
- DONE:
  - done = 1 for exactly this cycle; result_hi/result_lo are updated from hi/lo at entry and valid in this cycle.
  - Next state is IDLE.
- Result holding: result_hi/result_lo hold their values until the next DONE or reset.
- Single adder32 instance, muxed operands: RUN uses (hi, mcand/0, 0); NEG_LO/NEG_HI use the negation operands.
- Latency is fixed regardless of operands or sign:
  - start sampled at edge 0.
  - RUN covers edges 1..32, NEG_LO edge 33, NEG_HI edge 34.
  - done is high in the cycle after edge 34, i.e. 35 cycles after start.
- busy is 1 in RUN, NEG_LO, NEG_HI and DONE; 0 in IDLE.
- start while busy=1 is ignored: no queueing, and operands are not re-sampled.
- start in the DONE cycle is also ignored; it is accepted from IDLE only.
- Reset mid-operation returns to IDLE immediately. done is never pulsed for the aborted operation.
- No overflow output; the 64-bit product is always exact.

Decomposition:
- Package mult32_pkg holds:
  - state enum/localparams (IDLE=0, RUN=1, NEG_LO=2, NEG_HI=3, DONE=4), 3 bits;
  - MULT_WIDTH=32;
  - MULT_ITER=32;
  - MULT_LATENCY=35.
- One sub-module: the existing adder32, instantiated once, Cin driven per state.
- Operand abs/negate at load may use a local combinational expression; no new module.

Test Plan:
- Unsigned, a=3, b=5: start at cycle 0 -> done exactly at cycle 35; result_hi=0x00000000, result_lo=0x0000000F; busy high cycles 1-35.
- Unsigned, a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001.
- Signed, a=0xFFFFFFFD (-3), b=5 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1; signed a=b=0xFFFFFFFF -> result_hi=0, result_lo=1; same operands unsigned -> as the second scenario.
- Signed, a=b=0x80000000 -> result_hi=0x40000000, result_lo=0x00000000; signed a=0x80000000, b=1 -> result_hi=0xFFFFFFFF, result_lo=0x80000000.
- Handshake:
  - second start with different operands at cycle 10 -> ignored; first result returned at cycle 35.
  - start held high continuously -> a new operation starts only from IDLE (cycle 36); next done at cycle 71.
- Reset asserted asynchronously at cycle 12 of an operation -> busy/done/result_* = 0 immediately with no done pulse; a new start after release completes normally in 35 cycles.
